seg7_scan_counter: RTL
======================

Name: seg7_scan_counter

Overview:
- Multi-digit free-running counter that drives a time-multiplexed common-cathode/anode 7-segment display.
- Parametrised in digit count, radix (BCD or hex), count rate, scan rate and output polarity.
- Adds up/down counting, run/clear control, wrap indication and ghost-free digit scanning.
- Sits at the FPGA top level between the board clock/reset and the display pins.

Parameters:
- CLK_HZ, 48000000, input clock frequency.
- COUNT_HZ, 1, count tick rate; prescale period P = CLK_HZ/COUNT_HZ cycles.
- SCAN_HZ, 1000, full-display refresh rate; per-digit slot S = CLK_HZ/(SCAN_HZ*DIGITS) cycles, S >= 2.
- DIGITS, 4, number of display digits, 1..8.
- RADIX_BCD, 1, 1: each digit 0-9; 0: each digit 0-F.
- ACTIVE_LOW, 1, 1: seg7 and dig_sel are driven active-low; 0: active-high.

Ports:
- clk  in  1  system clock, CLK_HZ.
- res_n  in  1  reset; asynchronous assert, active-low.
- run  in  1  count enable; sampled on tick.
- up  in  1  direction: 1 = increment, 0 = decrement.
- clr  in  1  synchronous clear of count and prescaler.
- seg7  out  7  segments {a,b,c,d,e,f,g}, a = MSB; polarity set by ACTIVE_LOW.
- dig_sel  out  DIGITS  one-hot digit enable; polarity set by ACTIVE_LOW.
- value  out  4*DIGITS  current count, digit 0 in [3:0] (least significant).
- wrap  out  1  one-cycle pulse on count roll-over or roll-under.

Behaviour:
- Reset (res_n low, asynchronous): prescaler = 0, all digits = 0, scan index = 0, blank = 1, wrap = 0. All seg7 and dig_sel lines are driven inactive (all 1s if ACTIVE_LOW).
- Prescaler: 32-bit counter running 0..P-1. tick = (prescaler == P-1); prescaler returns to 0 on the same edge. The prescaler free-runs regardless of run.
- Clear: clr has priority over tick. clr zeroes the digits and the prescaler, and wrap stays 0.
- Count update on tick && run && !clr, applied at that edge:
  - up = 1: digit 0 increments. A digit at its max (9 in BCD, F in hex) goes to 0 and carries to the next digit.
  - up = 0: digit 0 decrements. A digit at 0 goes to max and borrows from the next digit.
  - Carry/borrow ripple combinationally through all digits within one cycle.
- Wrap:
  - wrap = 1 for exactly the cycle after the update edge in which all digits went max to 0 (up) or 0 to max (down).
  - Example, DIGITS = 4 BCD: 9999 -> 0000 and 0000 -> 9999.
- Hex mode digit values A-F are legal. In BCD mode an illegal digit value (unreachable) counts as max and carries.
- run = 0 on a tick: the count holds and wrap stays 0.
- Scan FSM, states BLANK and SHOW, with a slot counter 0..S-1:
  - BLANK lasts 1 cycle: dig_sel all inactive, seg7 all inactive.
  - SHOW lasts S-1 cycles: dig_sel[idx] active, seg7 = pattern(digit[idx]).
  - At the end of SHOW: idx = (idx == DIGITS-1) ? 0 : idx+1, and the FSM returns to BLANK.
  - After reset the first state is BLANK with idx 0.
- Outputs seg7 and dig_sel are registered. They reflect the state/idx/digit value of the previous cycle, so a count change is visible on the displayed digit one cycle after value changes.
- Patterns, active-high before polarity:
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001
  - 4 = 0110011, 5 = 1011011, 6 = 1011111, 7 = 1110000
  - 8 = 1111111, 9 = 1111011, A = 1110111, b = 0011111
  - C = 1001110, d = 0111101, E = 1001111, F = 1000111
- Polarity: ACTIVE_LOW inverts both seg7 and dig_sel at the output register input.
- Reset mid-scan or mid-count: immediate return to the reset values. No partial update survives.
- value is the direct digit register content, with no extra latency.

Decomposition:
- Package seg7_pkg holds:
  - the segment pattern constants and function hex_to_seg7 (4-bit in, 7-bit active-high out);
  - a function digit_max(radix_bcd) returning 9 or 15;
  - the scan state enum {BLANK, SHOW}.
- Sub-module seg7_digit_cell: one 4-bit digit with inc, dec, cin, and cout/bout outputs, parametrised by RADIX_BCD. It is instantiated DIGITS times in a generate loop.
- The prescaler, scan FSM and output registers live in seg7_scan_counter.

Test Plan:
- Bench parameters unless stated: CLK_HZ = 100, COUNT_HZ = 10 (P = 10), SCAN_HZ = 5, DIGITS = 4 (S = 5).
- Reset release, run = 1, up = 1: first tick at cycle 10 -> value 0x0001. After 12 ticks -> 0x0012 (BCD). wrap stays 0.
- Preload to 9999 via 9999 ticks (or force): next tick -> value 0x0000 and a single wrap pulse. Repeat with RADIX_BCD = 0 from FFFF -> 0000.
- From 0000 with up = 0: one tick -> 9999 and wrap pulse. Next tick -> 9998. run = 0 across 3 ticks -> value holds at 9998.
- clr asserted in the same cycle as a tick at value 0x0037 -> value 0x0000, prescaler 0, no wrap. The next tick arrives 10 cycles after clr.
- Scan with value 0x1234, ACTIVE_LOW = 1: dig_sel cycles 1111 (blank, 1 cycle), then 1110 for 4 cycles with seg7 = ~0110011 (digit 4), then blank, then 1101 with seg7 = ~1111001 (digit 3), and so on, returning to digit 0 after 20 cycles.
- Assert res_n low mid-SHOW with value 0x0567 -> seg7 = 1111111, dig_sel = 1111 and value = 0 asynchronously. After release, the first state is BLANK with idx 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and helpers for the multiplexed 7-segment counter:
// segment patterns, digit limits and the scan state encoding.
package seg7_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

    // Segment order is {a,b,c,d,e,f,g}, active-high.
    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b0011111;
    localparam logic [6:0] SEG_C = 7'b1001110;
    localparam logic [6:0] SEG_D = 7'b0111101;
    localparam logic [6:0] SEG_E = 7'b1001111;
    localparam logic [6:0] SEG_F = 7'b1000111;

    function automatic logic [6:0] hex_to_seg7(input logic [3:0] digit);
        logic [6:0] seg;
        seg = SEG_0;
        case (digit)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
        return seg;
    endfunction

    function automatic logic [3:0] digit_max(input logic radix_bcd);
        return radix_bcd ? 4'd9 : 4'd15;
    endfunction

endpackage

// File: rtl/seg7_digit_cell.sv
// One counter digit. inc_i/dec_i step the digit; cout_o/bout_o tell the next
// digit up that this one rolled over (max->0) or under (0->max).
module seg7_digit_cell
    import seg7_pkg::*;
#(
    parameter int RADIX_BCD = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [3:0] digit_o,
    output logic       cout_o,
    output logic       bout_o
);

    localparam logic [3:0] MAX = digit_max(RADIX_BCD != 0);

    logic [3:0] digit_q, digit_d;
    logic       at_max, at_zero;

    // Anything above MAX (only possible in BCD) is treated as MAX.
    assign at_max  = (digit_q >= MAX);
    assign at_zero = (digit_q == 4'd0);
    assign cout_o  = inc_i & at_max;
    assign bout_o  = dec_i & at_zero;
    assign digit_o = digit_q;

    always_comb begin
        digit_d = digit_q;
        if (clr_i) begin
            digit_d = 4'd0;
        end else if (inc_i) begin
            digit_d = at_max ? 4'd0 : digit_q + 4'd1;
        end else if (dec_i) begin
            if (at_zero)
                digit_d = MAX;
            else if (at_max)
                digit_d = MAX - 4'd1;
            else
                digit_d = digit_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            digit_q <= 4'd0;
        else
            digit_q <= digit_d;
    end

endmodule

// File: rtl/seg7_scan_counter.sv
// Multi-digit up/down counter with a time-multiplexed 7-segment display driver.
//   state | meaning
//   BLANK | one cycle with all digits and segments off, avoids ghosting
//   SHOW  | S-1 cycles driving digit idx and its segment pattern
module seg7_scan_counter
    import seg7_pkg::*;
#(
    parameter int CLK_HZ     = 48000000,
    parameter int COUNT_HZ   = 1,
    parameter int SCAN_HZ    = 1000,
    parameter int DIGITS     = 4,
    parameter int RADIX_BCD  = 1,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  res_n,
    input  logic                  run,
    input  logic                  up,
    input  logic                  clr,
    output logic [6:0]            seg7,
    output logic [DIGITS-1:0]     dig_sel,
    output logic [4*DIGITS-1:0]   value,
    output logic                  wrap
);

    localparam int P     = CLK_HZ / COUNT_HZ;
    localparam int S     = CLK_HZ / (SCAN_HZ * DIGITS);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [31:0]       P_LAST   = 32'(P - 1);
    localparam logic [31:0]       S_LAST   = 32'(S - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [6:0]        SEG_OFF  = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] DIG_OFF  = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [31:0] presc_q, presc_d;
    logic        tick, step;

    assign tick    = (presc_q == P_LAST);
    assign step    = tick & run & ~clr;
    assign presc_d = (clr || tick) ? 32'd0 : presc_q + 32'd1;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n)
            presc_q <= 32'd0;
        else
            presc_q <= presc_d;
    end

    logic [DIGITS-1:0]   inc_c, dec_c, cout_c, bout_c;
    logic [4*DIGITS-1:0] digits_w;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        if (g == 0) begin : g_lsd
            assign inc_c[g] = step & up;
            assign dec_c[g] = step & ~up;
        end else begin : g_upper
            assign inc_c[g] = cout_c[g-1];
            assign dec_c[g] = bout_c[g-1];
        end

        seg7_digit_cell #(
            .RADIX_BCD (RADIX_BCD)
        ) u_cell (
            .clk     (clk),
            .rst_n   (res_n),
            .clr_i   (clr),
            .inc_i   (inc_c[g]),
            .dec_i   (dec_c[g]),
            .digit_o (digits_w[4*g +: 4]),
            .cout_o  (cout_c[g]),
            .bout_o  (bout_c[g])
        );
    end

    // A carry or borrow out of the top digit means every digit rolled.
    logic wrap_q, wrap_d;
    assign wrap_d = up ? cout_c[DIGITS-1] : bout_c[DIGITS-1];

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n)
            wrap_q <= 1'b0;
        else
            wrap_q <= wrap_d;
    end

    scan_state_e      state_q, state_d;
    logic [31:0]      slot_q, slot_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= BLANK;
            slot_q  <= 32'd0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        idx_d   = idx_q;
        case (state_q)
            BLANK: begin
                state_d = SHOW;
                slot_d  = 32'd1;
            end
            SHOW: begin
                if (slot_q == S_LAST) begin
                    state_d = BLANK;
                    slot_d  = 32'd0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                end else begin
                    slot_d = slot_q + 32'd1;
                end
            end
            default: begin
                state_d = BLANK;
                slot_d  = 32'd0;
            end
        endcase
    end

    logic [3:0]        cur_digit;
    logic [6:0]        seg_raw, seg7_q, seg7_d;
    logic [DIGITS-1:0] sel_raw, dig_q, dig_d;

    always_comb begin
        cur_digit = 4'd0;
        sel_raw   = '0;
        seg_raw   = 7'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i))
                cur_digit = digits_w[4*i +: 4];
        end
        if (state_q == SHOW) begin
            sel_raw[idx_q] = 1'b1;
            seg_raw        = hex_to_seg7(cur_digit);
        end
        seg7_d = (ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
        dig_d  = (ACTIVE_LOW != 0) ? ~sel_raw : sel_raw;
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            seg7_q <= SEG_OFF;
            dig_q  <= DIG_OFF;
        end else begin
            seg7_q <= seg7_d;
            dig_q  <= dig_d;
        end
    end

    assign seg7    = seg7_q;
    assign dig_sel = dig_q;
    assign value   = digits_w;
    assign wrap    = wrap_q;

endmodule
